mips_register_file: RTL and testbench

//  32 x 32-bit general-purpose register file of the single-cycle MIPS datapath.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/mips_regfile_read_port.sv | 26 ++
 rtl/mips_register_file.sv | 67 ++++++
 tb/tb_mips_register_file.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS datapath: widths, special
// register indices and ALU operation encodings.
package mips_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;

    localparam int REG_ZERO = 0;
    localparam int REG_SP   = 29;
    localparam int REG_RA   = 31;

    // {binvert, sel[1:0]}; binvert turns ADD into SUB and drives the SLT compare
    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_t;

endpackage

// File: rtl/mips_regfile_read_port.sv
// One combinational read port: array index, optional write->read forwarding,
// and the $zero override, which wins over everything else.
module mips_regfile_read_port #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int BYPASS     = 1
) (
    input  logic [DATA_WIDTH-1:0] regs [2**ADDR_WIDTH],
    input  logic [ADDR_WIDTH-1:0] read_reg,
    input  logic                  fwd_en,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data
);

    always_comb begin
        read_data = regs[read_reg];
        if ((BYPASS != 0) && fwd_en && (write_reg == read_reg)) begin
            read_data = write_data;
        end
        if (read_reg == '0) begin
            read_data = '0;
        end
    end

endmodule

// File: rtl/mips_register_file.sv
// 32 x 32 register file: two combinational read ports, one synchronous write
// port with synchronous clear; writes to $zero are dropped.
module mips_register_file #(
    parameter int DATA_WIDTH = mips_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = mips_pkg::REG_ADDR_WIDTH,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] read_reg1,
    input  logic [ADDR_WIDTH-1:0] read_reg2,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  reg_write,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2
);

    import mips_pkg::*;

    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic                  write_en;
    logic                  fwd_en;

    assign write_en = reg_write && (write_reg != ADDR_WIDTH'(REG_ZERO));
    // Forwarding only mirrors a write that will actually land on this edge.
    assign fwd_en   = !rst && write_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (write_en) begin
            regs[write_reg] <= write_data;
        end
    end

    mips_regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .BYPASS     (BYPASS)
    ) u_read_port1 (
        .regs       (regs),
        .read_reg   (read_reg1),
        .fwd_en     (fwd_en),
        .write_reg  (write_reg),
        .write_data (write_data),
        .read_data  (read_data1)
    );

    mips_regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .BYPASS     (BYPASS)
    ) u_read_port2 (
        .regs       (regs),
        .read_reg   (read_reg2),
        .fwd_en     (fwd_en),
        .write_reg  (write_reg),
        .write_data (write_data),
        .read_data  (read_data2)
    );

endmodule

// File: tb/tb_mips_register_file.sv
// Bench for mips_register_file: forwarding and non-forwarding instances share
// stimulus and are compared against a plain array model of the register file.
module tb_mips_register_file;

    logic        clk;
    logic        rst;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        reg_write;
    logic [31:0] rd1_byp, rd2_byp;
    logic [31:0] rd1_nb, rd2_nb;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] model [32];

    mips_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .write_reg  (write_reg),
        .write_data (write_data),
        .reg_write  (reg_write),
        .read_data1 (rd1_byp),
        .read_data2 (rd2_byp)
    );

    mips_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(0)) dut_nb (
        .clk        (clk),
        .rst        (rst),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .write_reg  (write_reg),
        .write_data (write_data),
        .reg_write  (reg_write),
        .read_data1 (rd1_nb),
        .read_data2 (rd2_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t got=%08h exp=%08h", tag, $time, got, exp);
        end
    endtask

    // What a register read should show right now, given the pending write.
    function automatic logic [31:0] exp_read(input logic [4:0] idx, input bit fwd);
        if (idx == 5'd0) return 32'h0;
        if (fwd && !rst && reg_write && write_reg != 5'd0 && write_reg == idx) return write_data;
        return model[idx];
    endfunction

    task automatic apply(input logic r, input logic w, input logic [4:0] wr,
                         input logic [31:0] wd, input logic [4:0] a, input logic [4:0] b);
        rst        = r;
        reg_write  = w;
        write_reg  = wr;
        write_data = wd;
        read_reg1  = a;
        read_reg2  = b;
        #1;
        chk("rd1_byp", rd1_byp, exp_read(a, 1'b1));
        chk("rd2_byp", rd2_byp, exp_read(b, 1'b1));
        chk("rd1_nb",  rd1_nb,  exp_read(a, 1'b0));
        chk("rd2_nb",  rd2_nb,  exp_read(b, 1'b0));
    endtask

    task automatic tick;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (reg_write && write_reg != 5'd0) begin
            model[write_reg] = write_data;
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        rst = 1'b1; reg_write = 1'b0; write_reg = '0; write_data = '0;
        read_reg1 = '0; read_reg2 = '0;
        tick();

        // reset sweep
        for (int i = 0; i < 32; i++) begin
            apply(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
            chk("rst_sweep1", rd1_byp, 32'h0);
            chk("rst_sweep2", rd2_byp, 32'h0);
        end

        // plain write and neighbours
        apply(1'b0, 1'b1, 5'd8, 32'hDEADBEEF, 5'd7, 5'd9);
        tick();
        apply(1'b0, 1'b0, 5'd0, 32'h0, 5'd8, 5'd7);
        chk("r8_write", rd1_byp, 32'hDEADBEEF);
        chk("r7_clean", rd2_byp, 32'h0);
        apply(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd8);
        chk("r9_clean", rd1_byp, 32'h0);
        chk("r8_nb", rd2_nb, 32'hDEADBEEF);

        // write to $zero is dropped
        apply(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        chk("zero_pre1", rd1_byp, 32'h0);
        chk("zero_pre2", rd2_byp, 32'h0);
        tick();
        apply(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        chk("zero_post1", rd1_byp, 32'h0);
        chk("zero_post2", rd2_nb, 32'h0);

        // same-cycle forwarding vs array contents
        apply(1'b0, 1'b1, 5'd5, 32'h11111111, 5'd0, 5'd0);
        tick();
        apply(1'b0, 1'b1, 5'd5, 32'h22222222, 5'd5, 5'd5);
        chk("byp_pre", rd1_byp, 32'h22222222);
        chk("nobyp_pre", rd1_nb, 32'h11111111);
        tick();
        apply(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        chk("nobyp_post", rd1_nb, 32'h22222222);

        // X on write_data with write disabled
        apply(1'b0, 1'b0, 5'd8, 32'hxxxxxxxx, 5'd8, 5'd5);
        tick();
        apply(1'b0, 1'b0, 5'd0, 32'h0, 5'd8, 5'd5);
        chk("x_guard8", rd1_byp, 32'hDEADBEEF);
        chk("x_guard5", rd2_byp, 32'h22222222);

        // reset beats a simultaneous write
        apply(1'b0, 1'b1, 5'd31, 32'h12345678, 5'd0, 5'd0);
        tick();
        apply(1'b1, 1'b1, 5'd31, 32'hAAAAAAAA, 5'd31, 5'd31);
        chk("rst_nofwd", rd1_byp, 32'h12345678);
        tick();
        apply(1'b0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd8);
        chk("rst_r31", rd1_byp, 32'h0);
        chk("rst_r8", rd2_byp, 32'h0);

        // both ports on the register being written
        apply(1'b0, 1'b1, 5'd29, 32'h7FFFFFFC, 5'd29, 5'd29);
        chk("sp_pre_eq", rd1_byp, rd2_byp);
        tick();
        apply(1'b0, 1'b0, 5'd0, 32'h0, 5'd29, 5'd29);
        chk("sp_post1", rd1_byp, 32'h7FFFFFFC);
        chk("sp_post2", rd2_byp, 32'h7FFFFFFC);

        // random regression
        for (int n = 0; n < 10000; n++) begin
            logic       r, w;
            logic [4:0] wr, a, b;
            r  = ($urandom_range(63) == 0);
            w  = 1'($urandom_range(1));
            wr = 5'($urandom);
            a  = ($urandom_range(3) == 0) ? wr : 5'($urandom);
            b  = ($urandom_range(3) == 0) ? wr : 5'($urandom);
            apply(r, w, wr, $urandom, a, b);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
